regfile_bank32: RTL and testbench
=================================

Name: regfile_bank32

Overview:
- Storage and write stage of the register file. Holds NREGS architectural registers and feeds all of them in parallel to the downstream 32:1 read multiplexer.
- Accepts write requests over a valid/ready handshake, with per-byte write masks and a one-stage write pipeline.
- Supports a bulk clear command, executed by a counter-driven FSM at one register per cycle.

Parameters:
- DW, 32, data width per register; must be a multiple of 8.
- AW, 5, address width.
- NREGS, 32, register count; must equal 2**AW.
- ZERO_R0, 0, when 1, register 0 reads as 0 permanently and writes to it are dropped.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request can be accepted.
- wr_addr  in  AW  target register index.
- wr_data  in  DW  write data.
- wr_mask  in  DW/8  byte enables; bit i covers bits [8i+7:8i].
- clr_req  in  1  single-cycle pulse requesting a clear of all registers.
- busy  out  1  high while a clear is in progress.
- clr_done  out  1  one-cycle pulse when a clear completes.
- q_all  out  NREGS*DW  flattened register contents; register k occupies bits [k*DW+DW-1 : k*DW]; the integration slices this into the mux inputs q0..q31.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all registers 0, so q_all=0; FSM=IDLE; clear counter=0; pending stage invalid; wr_ready=1; busy=0; clr_done=0.
- Reset mid-operation: asserting rst_n low during a clear or with a pending write aborts everything and returns to the reset state immediately. No partial write survives.
- FSM states are IDLE and CLEAR.
- IDLE:
  - wr_ready=1. The value is combinational from state only and never depends on wr_valid or clr_req.
  - clr_req=1 moves the FSM to CLEAR on the next edge, with counter=0.
- CLEAR:
  - wr_ready=0 and busy=1.
  - Each edge zeroes reg[counter], then increments the counter.
  - On the edge that clears index NREGS-1, the FSM returns to IDLE, counter goes to 0, and clr_done=1 for exactly the following cycle.
  - The clear takes exactly NREGS cycles in CLEAR.
  - clr_req received while in CLEAR is ignored and is not queued.
- Write pipeline:
  - Handshake: wr_valid&&wr_ready at edge N captures addr, data and mask into the pending stage.
  - At edge N+1 the pending entry commits: for each set mask bit, the corresponding byte of reg[addr] takes the new data; unmasked bytes hold their value.
  - The new value is visible on q_all from the cycle after edge N+1, i.e. 2-cycle latency from presenting the request.
  - Throughput is one write per cycle in IDLE.
  - Back-to-back writes to the same address commit in order; the last write wins.
  - A write with wr_mask=0 completes the handshake and changes nothing.
  - With ZERO_R0=1, a write to address 0 completes the handshake and is discarded; reg[0] is constant 0.
- Simultaneous wr_valid and clr_req in IDLE:
  - The write is accepted (wr_ready=1 that cycle) and the clear begins on the same edge.
  - The pending write commits on the first CLEAR edge.
  - If the pending address equals the clear counter on that edge, the clear wins.
  - Net result: every register is 0 when clr_done fires.
- q_all is purely registered, with no combinational path from inputs.

Decomposition:
- Shared package regfile_pkg:
  - constants REGFILE_DW, REGFILE_AW, REGFILE_NREGS;
  - state enum {ST_IDLE, ST_CLEAR};
  - helper function for byte-masked merge of old and new data (DW, mask).
- Natural sub-module: regfile_wr_pipe, the one-entry capture register holding pending valid, addr, data and mask. It is reused by any future second write port.
- Storage array, clear FSM and counter stay in the top module.

Test Plan:
- Reset → q_all=0, wr_ready=1, busy=0, clr_done=0.
  - Assert rst_n low asynchronously mid-cycle → outputs clear without waiting for a clk edge.
- Write addr=5, data=0xDEADBEEF, mask=0xF at cycle 0 → q_all slice 5 = 0xDEADBEEF from cycle 2; all other slices remain 0.
- Partial masks:
  - With reg5=0xDEADBEEF, write 0x12345678 mask=0x3 → reg5=0xDEAD5678.
  - Then mask=0x0 → reg5 unchanged and handshake completes.
- Back-to-back writes:
  - addr=7 data=0x1 at cycle 0, then addr=7 data=0x2 at cycle 1 → reg7=0x1 in cycle 2, 0x2 from cycle 3.
- Clear with concurrent write:
  - Setup: load regs 1..31 nonzero.
  - Stimulus: clr_req together with a write of 0xFFFFFFFF to addr=0 (with ZERO_R0=0).
  - Required response: busy high for exactly 32 cycles and wr_ready low throughout; one-cycle clr_done pulse; q_all=0 afterwards; a second clr_req during the clear is ignored.
- ZERO_R0=1: write 0xAAAA5555 to addr 0 → reg0 stays 0.
  - Start a clear, assert rst_n at counter=10 → immediate IDLE, all zero, no clr_done pulse.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, constants and helpers for the register file bank.
package regfile_pkg;

    localparam int unsigned REGFILE_DW    = 32;
    localparam int unsigned REGFILE_AW    = 5;
    localparam int unsigned REGFILE_NREGS = 32;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_CLEAR
    } regfile_state_e;

    // Byte-masked merge: set mask bits take the new byte, clear bits keep the old one.
    function automatic logic [REGFILE_DW-1:0] byte_merge(
        input logic [REGFILE_DW-1:0]   old_data,
        input logic [REGFILE_DW-1:0]   new_data,
        input logic [REGFILE_DW/8-1:0] mask
    );
        logic [REGFILE_DW-1:0] res;
        res = old_data;
        for (int i = 0; i < int'(REGFILE_DW / 8); i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_wr_pipe.sv
// One-entry write capture stage: holds a pending write for exactly one cycle.
module regfile_wr_pipe #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cap_en,
    input  logic [AW-1:0]   cap_addr,
    input  logic [DW-1:0]   cap_data,
    input  logic [DW/8-1:0] cap_mask,
    output logic            pend_valid,
    output logic [AW-1:0]   pend_addr,
    output logic [DW-1:0]   pend_data,
    output logic [DW/8-1:0] pend_mask
);

    logic            valid_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic [DW/8-1:0] mask_q;

    // Capture an accepted request; the valid flag drops after one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            valid_q <= cap_en;
            if (cap_en) begin
                addr_q <= cap_addr;
                data_q <= cap_data;
                mask_q <= cap_mask;
            end
        end
    end

    assign pend_valid = valid_q;
    assign pend_addr  = addr_q;
    assign pend_data  = data_q;
    assign pend_mask  = mask_q;

endmodule

// File: rtl/regfile_bank32.sv
// Register file storage with a pipelined byte-masked write port and a
// counter-driven bulk clear (one register per cycle).
module regfile_bank32
    import regfile_pkg::*;
#(
    parameter int unsigned DW      = REGFILE_DW,
    parameter int unsigned AW      = REGFILE_AW,
    parameter int unsigned NREGS   = REGFILE_NREGS,
    parameter int unsigned ZERO_R0 = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic [DW/8-1:0]     wr_mask,
    input  logic                clr_req,
    output logic                busy,
    output logic                clr_done,
    output logic [NREGS*DW-1:0] q_all
);

    regfile_state_e state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;

    logic [NREGS*DW-1:0] mem_q;

    logic            pend_valid;
    logic [AW-1:0]   pend_addr;
    logic [DW-1:0]   pend_data;
    logic [DW/8-1:0] pend_mask;
    logic            commit_en;
    logic            cap_en;

    // Handshake outputs depend on state only.
    always_comb begin
        wr_ready = (state_q == ST_IDLE);
        busy     = (state_q == ST_CLEAR);
        cap_en   = wr_valid && wr_ready;
    end

    regfile_wr_pipe #(
        .DW (DW),
        .AW (AW)
    ) u_wr_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .cap_en     (cap_en),
        .cap_addr   (wr_addr),
        .cap_data   (wr_data),
        .cap_mask   (wr_mask),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr),
        .pend_data  (pend_data),
        .pend_mask  (pend_mask)
    );

    // Clear FSM next-state: walk the counter through every index, then pulse done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM, counter and done-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Writes to register 0 are dropped when it is hard-wired to zero.
    always_comb begin
        commit_en = pend_valid && !((ZERO_R0 != 0) && (pend_addr == '0));
    end

    // Storage: commit the pending write, then let the clear override the same index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            if (commit_en) begin
                mem_q[pend_addr*DW +: DW] <=
                    byte_merge(mem_q[pend_addr*DW +: DW], pend_data, pend_mask);
            end
            if (state_q == ST_CLEAR) begin
                mem_q[cnt_q*DW +: DW] <= '0;
            end
        end
    end

    assign q_all    = mem_q;
    assign clr_done = done_q;

endmodule

// File: tb/tb_regfile_bank32.sv
// Self-checking bench for regfile_bank32: one instance with ZERO_R0=0 and one
// with ZERO_R0=1 share the same stimulus; a scoreboard holds expected register
// values keyed by the cycle at which they must appear on q_all.
module tb_regfile_bank32;

    logic          clk;
    logic          rst_n;
    logic          wr_valid;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_mask;
    logic          clr_req;
    logic          wr_ready0, wr_ready1;
    logic          busy0, busy1;
    logic          clr_done0, clr_done1;
    logic [1023:0] q0, q1;

    regfile_bank32 #(
        .DW      (32),
        .AW      (5),
        .NREGS   (32),
        .ZERO_R0 (0)
    ) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready0),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask),
        .clr_req  (clr_req),
        .busy     (busy0),
        .clr_done (clr_done0),
        .q_all    (q0)
    );

    regfile_bank32 #(
        .DW      (32),
        .AW      (5),
        .NREGS   (32),
        .ZERO_R0 (1)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready1),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask),
        .clr_req  (clr_req),
        .busy     (busy1),
        .clr_done (clr_done1),
        .q_all    (q1)
    );

    typedef struct {
        int          due;
        int          dut;
        int          addr;
        logic [31:0] val;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] mdl0[32];
    logic [31:0] mdl1[32];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slice(input int dut, input int k);
        if (dut == 0) return q0[k*32 +: 32];
        return q1[k*32 +: 32];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    // Scoreboard consumer: compare every entry that falls due this cycle.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb_q.size()) begin
            if (sb_q[i].due == cyc) begin
                check_val($sformatf("sb d%0d r%0d c%0d", sb_q[i].dut, sb_q[i].addr, cyc),
                          slice(sb_q[i].dut, sb_q[i].addr), sb_q[i].val);
                sb_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 32; k++) begin
            mdl0[k] = '0;
            mdl1[k] = '0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 32; k++) begin
            check_val($sformatf("%s d0 r%0d", tag, k), slice(0, k), mdl0[k]);
            check_val($sformatf("%s d1 r%0d", tag, k), slice(1, k), mdl1[k]);
        end
    endtask

    // Present one write for one cycle; expected values land 2 cycles later.
    task automatic do_write(input int addr, input logic [31:0] data, input logic [3:0] mask);
        sb_t e;
        wr_valid = 1'b1;
        wr_addr  = 5'(addr);
        wr_data  = data;
        wr_mask  = mask;
        check_val("wr_ready d0", 32'(wr_ready0), 32'd1);
        check_val("wr_ready d1", 32'(wr_ready1), 32'd1);
        mdl0[addr] = merge(mdl0[addr], data, mask);
        if (addr != 0) mdl1[addr] = merge(mdl1[addr], data, mask);
        e.due = cyc + 2; e.addr = addr;
        e.dut = 0; e.val = mdl0[addr]; sb_q.push_back(e);
        e.dut = 1; e.val = mdl1[addr]; sb_q.push_back(e);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_mask  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n[2];
        int done_n[2];
        int done_at[2];
        int rdy_bad[2];

        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_mask  = '0;
        clr_req  = 1'b0;
        clear_model();

        // Reset state
        #3;
        check_val("rst wr_ready d0", 32'(wr_ready0), 32'd1);
        check_val("rst busy d0", 32'(busy0), 32'd0);
        check_val("rst clr_done d0", 32'(clr_done0), 32'd0);
        check_val("rst wr_ready d1", 32'(wr_ready1), 32'd1);
        check_val("rst busy d1", 32'(busy1), 32'd0);
        check_val("rst clr_done d1", 32'(clr_done1), 32'd0);
        check_all("rst");
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Full write, then partial and empty masks on the same register
        do_write(5, 32'hDEAD_BEEF, 4'hF);
        idle(2);
        check_all("wr5");
        do_write(5, 32'h1234_5678, 4'h3);
        do_write(5, 32'hFFFF_FFFF, 4'h0);
        idle(2);

        // Back-to-back writes to the same register
        do_write(7, 32'h1, 4'hF);
        do_write(7, 32'h2, 4'hF);
        idle(2);

        // Register 0 write: kept by dut0, dropped by dut1
        do_write(0, 32'hAAAA_5555, 4'hF);
        idle(2);
        check_all("r0");

        // Load registers 1..31 with nonzero values
        for (int k = 1; k < 32; k++) begin
            do_write(k, 32'h1000_0000 + 32'(k) * 32'h0101_0101, 4'hF);
        end
        idle(2);
        check_all("load");

        // Clear together with a write to register 0
        clr_req  = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 5'd0;
        wr_data  = 32'hFFFF_FFFF;
        wr_mask  = 4'hF;
        check_val("clr+wr wr_ready d0", 32'(wr_ready0), 32'd1);
        check_val("clr+wr wr_ready d1", 32'(wr_ready1), 32'd1);
        @(posedge clk);
        #1;
        clr_req  = 1'b0;
        wr_valid = 1'b0;
        wr_mask  = '0;
        for (int d = 0; d < 2; d++) begin
            busy_n[d] = 0; done_n[d] = 0; done_at[d] = -1; rdy_bad[d] = 0;
        end
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (busy0) busy_n[0]++;
            if (busy1) busy_n[1]++;
            if (busy0 && wr_ready0) rdy_bad[0]++;
            if (busy1 && wr_ready1) rdy_bad[1]++;
            if (clr_done0) begin done_n[0]++; done_at[0] = i; end
            if (clr_done1) begin done_n[1]++; done_at[1] = i; end
            if (i == 5) begin
                // Second clear and a write attempt while busy: both must be ignored.
                clr_req  = 1'b1;
                wr_valid = 1'b1;
                wr_addr  = 5'd3;
                wr_data  = 32'h0BAD_0BAD;
                wr_mask  = 4'hF;
            end
            if (i == 6) begin
                clr_req  = 1'b0;
                wr_valid = 1'b0;
                wr_mask  = '0;
            end
        end
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("clr busy cycles d%0d", d), 32'(busy_n[d]), 32'd32);
            check_val($sformatf("clr done pulses d%0d", d), 32'(done_n[d]), 32'd1);
            check_val($sformatf("clr done cycle d%0d", d), 32'(done_at[d]), 32'd32);
            check_val($sformatf("clr wr_ready while busy d%0d", d), 32'(rdy_bad[d]), 32'd0);
        end
        clear_model();
        check_all("clr");

        // Clear interrupted by an asynchronous reset at counter 10
        do_write(20, 32'h2020_2020, 4'hF);
        do_write(30, 32'h3030_3030, 4'hF);
        idle(2);
        check_all("pre-abort");
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort busy d0", 32'(busy0), 32'd0);
        check_val("abort wr_ready d0", 32'(wr_ready0), 32'd1);
        check_val("abort clr_done d0", 32'(clr_done0), 32'd0);
        check_val("abort busy d1", 32'(busy1), 32'd0);
        check_val("abort wr_ready d1", 32'(wr_ready1), 32'd1);
        check_val("abort clr_done d1", 32'(clr_done1), 32'd0);
        clear_model();
        check_all("abort");
        idle(3);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            busy_n[d] = 0; done_n[d] = 0;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy0) busy_n[0]++;
            if (busy1) busy_n[1]++;
            if (clr_done0) done_n[0]++;
            if (clr_done1) done_n[1]++;
        end
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("post-abort busy d%0d", d), 32'(busy_n[d]), 32'd0);
            check_val($sformatf("post-abort clr_done d%0d", d), 32'(done_n[d]), 32'd0);
        end

        // Reset with a write sitting in the pending stage
        @(posedge clk);
        #1;
        wr_valid = 1'b1;
        wr_addr  = 5'd9;
        wr_data  = 32'h0000_0005;
        wr_mask  = 4'hF;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        wr_valid = 1'b0;
        wr_mask  = '0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        check_all("pend-abort");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        check_val("sb drain", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
